// File: rtl/ram_prog_loader_if.sv
// Program-word stream handshake between a word source and ram_prog_loader.
// A word transfers on a rising clock edge when in_valid and in_ready are both 1.
interface ram_prog_loader_if #(
  parameter int DBus = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [DBus-1:0] in_data;
  logic            in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/ram_prog_loader.sv
// ram_prog_loader: streams a program into RamChip at addresses 0,1,2,...
// and holds the Cpu in reset until the load session finishes. Once the
// session ends, the RAM bus is released (high-Z) so the Cpu owns it.
// Each word takes SETUP / STROBE (WE low) / HOLD cycles on the RAM bus.
// Optional build macro LOADER_VERIFY_EN adds a read-back check per word
// (RDSETUP/RDCHK) and the sticky err_verify output.
module ram_prog_loader #(
  parameter int ABus = 5,
  parameter int DBus = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  ram_prog_loader_if.slave in_if,
  output wire [ABus-1:0]   Address,
  inout  wire [DBus-1:0]   DataMem,
  output wire              CS,
  output wire              WE,
  output wire              OE,
  output logic             busy,
  output logic             done,
  output logic             cpu_hold,
  output logic [ABus:0]    count,
  output logic             err_overflow
`ifdef LOADER_VERIFY_EN
  ,
  output logic             err_verify
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    SETUP,
    STROBE,
    HOLD,
    DONE
`ifdef LOADER_VERIFY_EN
    ,
    RDSETUP,
    RDCHK
`endif
  } state_t;

  localparam logic [ABus-1:0] ADDR_MAX = '1;

  state_t          state_q, state_d;
  logic [ABus-1:0] addr_q, addr_d;
  logic [DBus-1:0] word_q, word_d;
  logic            last_q, last_d;
  logic [ABus:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            err_ovf_q, err_ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            in_ready_q, in_ready_d;
  logic            bus_en_q, bus_en_d;
  logic            data_en_q, data_en_d;
  logic            cs_q, cs_d;
  logic            we_q, we_d;
  logic            oe_q, oe_d;
`ifdef LOADER_VERIFY_EN
  logic            err_ver_q, err_ver_d;
`endif
  logic            new_session;
  logic            advance;

  // Next-state, datapath and registered-output decode for the load FSM.
  // Outputs are decoded from state_d so every bus pin comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    last_d    = last_q;
    count_d   = count_q;
    full_d    = full_q;
    err_ovf_d = err_ovf_q;
`ifdef LOADER_VERIFY_EN
    err_ver_d = err_ver_q;
`endif
    advance     = 1'b0;
    new_session = start && (state_q == IDLE || state_q == DONE);

    case (state_q)
      ACCEPT: begin
        if (in_if.in_valid && in_ready_q) begin
          word_d  = in_if.in_data;
          last_d  = in_if.in_last;
          state_d = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        count_d = count_q + (ABus+1)'(1);
`ifdef LOADER_VERIFY_EN
        state_d = RDSETUP;
`else
        advance = 1'b1;
`endif
      end
`ifdef LOADER_VERIFY_EN
      RDSETUP: state_d = RDCHK;
      RDCHK: begin
        if (DataMem != word_q) err_ver_d = 1'b1;
        advance = 1'b1;
      end
`endif
      DONE: begin
        if (in_if.in_valid && full_q) err_ovf_d = 1'b1;
      end
      default: ;
    endcase

    // Word finished: stop on last word or a full RAM, else next address.
    if (advance) begin
      if (last_q) begin
        state_d = DONE;
      end else if (addr_q == ADDR_MAX) begin
        state_d = DONE;
        full_d  = 1'b1;
      end else begin
        addr_d  = addr_q + ABus'(1);
        state_d = ACCEPT;
      end
    end

    if (new_session) begin
      state_d   = ACCEPT;
      addr_d    = '0;
      count_d   = '0;
      full_d    = 1'b0;
      err_ovf_d = 1'b0;
`ifdef LOADER_VERIFY_EN
      err_ver_d = 1'b0;
`endif
    end

    busy_d     = !(state_d == IDLE || state_d == DONE);
    done_d     = (state_d == DONE);
    cpu_hold_d = (state_d != DONE);
    in_ready_d = (state_d == ACCEPT);
    bus_en_d   = busy_d;
    data_en_d  = (state_d == SETUP || state_d == STROBE || state_d == HOLD);
    we_d       = (state_d != STROBE);
`ifdef LOADER_VERIFY_EN
    cs_d = !(data_en_d || state_d == RDSETUP || state_d == RDCHK);
    oe_d = !(state_d == RDSETUP || state_d == RDCHK);
`else
    cs_d = !data_en_d;
    oe_d = 1'b1;
`endif
  end

  // State and registered outputs; synchronous reset aborts any session.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      count_q    <= '0;
      full_q     <= 1'b0;
      err_ovf_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cpu_hold_q <= 1'b1;
      in_ready_q <= 1'b0;
      bus_en_q   <= 1'b0;
      data_en_q  <= 1'b0;
      cs_q       <= 1'b1;
      we_q       <= 1'b1;
      oe_q       <= 1'b1;
`ifdef LOADER_VERIFY_EN
      err_ver_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      last_q     <= last_d;
      count_q    <= count_d;
      full_q     <= full_d;
      err_ovf_q  <= err_ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cpu_hold_q <= cpu_hold_d;
      in_ready_q <= in_ready_d;
      bus_en_q   <= bus_en_d;
      data_en_q  <= data_en_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      oe_q       <= oe_d;
`ifdef LOADER_VERIFY_EN
      err_ver_q  <= err_ver_d;
`endif
    end
  end

  assign Address = bus_en_q  ? addr_q : 'z;
  assign DataMem = data_en_q ? word_q : 'z;
  assign CS      = bus_en_q  ? cs_q   : 1'bz;
  assign WE      = bus_en_q  ? we_q   : 1'bz;
  assign OE      = bus_en_q  ? oe_q   : 1'bz;

  assign in_if.in_ready = in_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign cpu_hold       = cpu_hold_q;
  assign count          = count_q;
  assign err_overflow   = err_ovf_q;
`ifdef LOADER_VERIFY_EN
  assign err_verify     = err_ver_q;
`endif

endmodule

// File: tb/tb_ram_prog_loader.sv
// Directed self-checking bench for ram_prog_loader with a RamChip model.
// Released bus lines are pulled up, so a released Address/DataMem reads all ones.
module tb_ram_prog_loader;
  localparam int ABus = 5;
  localparam int DBus = 5;

  logic clock = 1'b0;
  logic reset;
  logic start;
  always #5 clock = ~clock;

  ram_prog_loader_if #(.DBus(DBus)) in_if ();

  wire [ABus-1:0] Address;
  wire [DBus-1:0] DataMem;
  wire            CS, WE, OE;
  logic           busy, done, cpu_hold, err_overflow;
  logic [ABus:0]  count;
`ifdef LOADER_VERIFY_EN
  logic           err_verify;
`endif

  pullup (Address);
  pullup (DataMem);
  pullup (CS);
  pullup (WE);
  pullup (OE);

  ram_prog_loader #(.ABus(ABus), .DBus(DBus)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_if        (in_if),
    .Address      (Address),
    .DataMem      (DataMem),
    .CS           (CS),
    .WE           (WE),
    .OE           (OE),
    .busy         (busy),
    .done         (done),
    .cpu_hold     (cpu_hold),
    .count        (count),
    .err_overflow (err_overflow)
`ifdef LOADER_VERIFY_EN
    ,
    .err_verify   (err_verify)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // ---------------- RamChip model and write-pulse watcher ----------------
  logic [DBus-1:0] mem [0:(1<<ABus)-1];
  int unsigned     wr_cnt    = 0;
  int unsigned     pulse_err = 0;
  logic            corrupt_en = 1'b0;
  logic            prev_we = 1'b1, prev_cs = 1'b1, chk_hold = 1'b0;
  logic [ABus-1:0] prev_a = '0, hold_a = '0;
  logic [DBus-1:0] prev_d = '0, hold_d = '0;

  always @(posedge clock) begin
    if (CS === 1'b0 && WE === 1'b0) begin
      mem[Address] <= (corrupt_en && Address == 5'd1) ? (DataMem ^ 5'd1) : DataMem;
      wr_cnt <= wr_cnt + 1;
    end
    if (reset) begin
      chk_hold <= 1'b0;
    end else if (WE === 1'b0) begin
      if (prev_we !== 1'b1 || prev_cs !== 1'b0 || prev_a !== Address ||
          prev_d !== DataMem || CS !== 1'b0)
        pulse_err <= pulse_err + 1;
      chk_hold <= 1'b1;
      hold_a   <= Address;
      hold_d   <= DataMem;
    end else if (chk_hold) begin
      if (CS !== 1'b0 || Address !== hold_a || DataMem !== hold_d)
        pulse_err <= pulse_err + 1;
      chk_hold <= 1'b0;
    end
    prev_we <= WE;
    prev_cs <= CS;
    prev_a  <= Address;
    prev_d  <= DataMem;
  end

`ifdef LOADER_VERIFY_EN
  assign DataMem = (CS === 1'b0 && OE === 1'b0) ? mem[Address] : 'z;
`endif

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [DBus-1:0] d, input logic last,
                           input int unsigned max_cyc, output bit acc);
    acc = 1'b0;
    in_if.in_data  = d;
    in_if.in_last  = last;
    in_if.in_valid = 1'b1;
    for (int unsigned i = 0; i < max_cyc && !acc; i++) begin
      @(negedge clock);
      if (in_if.in_ready === 1'b1) acc = 1'b1;
      @(posedge clock); #1;
    end
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
  endtask

  task automatic wait_done(input int unsigned max_cyc, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < max_cyc && !ok; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1 || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b done=%b cpu_hold=%b err_ovf=%b want 0 0 1 0",
               busy, done, cpu_hold, err_overflow);
    end
    n_checks++;
    if (count !== 6'd0 || in_if.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_count_ready: count=%0d in_ready=%b want 0 0", count, in_if.in_ready);
    end
    n_checks++;
    if (Address !== 5'h1f || DataMem !== 5'h1f || CS !== 1'b1 || WE !== 1'b1 || OE !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_bus: A=%h D=%h CS=%b WE=%b OE=%b want released (1f 1f 1 1 1)",
               Address, DataMem, CS, WE, OE);
    end
`ifdef LOADER_VERIFY_EN
    n_checks++;
    if (err_verify !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err_verify: got %b want 0", err_verify);
    end
`endif
  endtask

  task automatic test_basic();
    logic [DBus-1:0] vals [3];
    bit acc, ok;
    int unsigned wr0, pe0;
    vals[0] = 5'd3; vals[1] = 5'd7; vals[2] = 5'd31;
    wr0 = wr_cnt; pe0 = pulse_err;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1 || in_if.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_start: busy=%b cpu_hold=%b in_ready=%b want 1 1 1",
               busy, cpu_hold, in_if.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      send_word(vals[i], (i == 2), 20, acc);
      n_checks++;
      if (!acc) begin
        n_fail++;
        $display("FAIL basic_accept%0d: word not accepted within 20 cycles", i);
      end
    end
    wait_done(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: done never rose"); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (mem[i] !== vals[i]) begin
        n_fail++;
        $display("FAIL basic_ram%0d: got %0d want %0d", i, mem[i], vals[i]);
      end
    end
    n_checks++;
    if (count !== 6'd3 || done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status: count=%0d done=%b cpu_hold=%b busy=%b want 3 1 0 0",
               count, done, cpu_hold, busy);
    end
    n_checks++;
    if (Address !== 5'h1f || DataMem !== 5'h1f || CS !== 1'b1 || WE !== 1'b1 || OE !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_bus_released: A=%h D=%h CS=%b WE=%b OE=%b want 1f 1f 1 1 1",
               Address, DataMem, CS, WE, OE);
    end
    n_checks++;
    if (wr_cnt - wr0 != 3 || pulse_err != pe0) begin
      n_fail++;
      $display("FAIL basic_we_pulses: writes=%0d pulse_errs=%0d want 3 0", wr_cnt - wr0, pulse_err - pe0);
    end
  endtask

  task automatic test_overflow();
    bit acc, ok;
    int unsigned nacc, wr0, ready_seen;
    logic [DBus-1:0] exp;
    wr0 = wr_cnt; nacc = 0;
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      exp = DBus'((i * 5 + 3) % 32);
      send_word(exp, 1'b0, 20, acc);
      if (acc) nacc++;
    end
    n_checks++;
    if (nacc != 32) begin n_fail++; $display("FAIL ovf_accepted: got %0d want 32", nacc); end
    wait_done(20, ok);
    n_checks++;
    if (!ok || count !== 6'd32 || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full_status: done=%b count=%0d err_ovf=%b want 1 32 0", done, count, err_overflow);
    end
    in_if.in_data = 5'd17; in_if.in_last = 1'b0; in_if.in_valid = 1'b1;
    ready_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (in_if.in_ready !== 1'b0) ready_seen++;
      @(posedge clock); #1;
    end
    in_if.in_valid = 1'b0;
    n_checks++;
    if (ready_seen != 0) begin n_fail++; $display("FAIL ovf_33rd_ready: in_ready high %0d cycles want 0", ready_seen); end
    n_checks++;
    if (err_overflow !== 1'b1 || count !== 6'd32 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag: err_ovf=%b count=%0d done=%b want 1 32 1", err_overflow, count, done);
    end
    n_checks++;
    if (wr_cnt - wr0 != 32) begin n_fail++; $display("FAIL ovf_writes: got %0d want 32", wr_cnt - wr0); end
    for (int i = 0; i < 32; i++) begin
      exp = DBus'((i * 5 + 3) % 32);
      n_checks++;
      if (mem[i] !== exp) begin
        n_fail++;
        $display("FAIL ovf_ram%0d: got %0d want %0d", i, mem[i], exp);
      end
    end
  endtask

  task automatic test_restart();
    bit acc, ok;
    int unsigned hold_low;
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b1 || err_overflow !== 1'b0 || count !== 6'd0) begin
      n_fail++;
      $display("FAIL restart_clear: done=%b cpu_hold=%b err_ovf=%b count=%0d want 0 1 0 0",
               done, cpu_hold, err_overflow, count);
    end
    hold_low = 0;
    send_word(5'd4, 1'b0, 20, acc);
    if (cpu_hold !== 1'b1) hold_low++;
    send_word(5'd5, 1'b1, 20, acc);
    if (cpu_hold !== 1'b1) hold_low++;
    n_checks++;
    if (hold_low != 0) begin n_fail++; $display("FAIL restart_cpu_hold: low %0d times during load want 0", hold_low); end
    wait_done(20, ok);
    n_checks++;
    if (!ok || mem[0] !== 5'd4 || mem[1] !== 5'd5 || count !== 6'd2) begin
      n_fail++;
      $display("FAIL restart_load: done=%b ram0=%0d ram1=%0d count=%0d want 1 4 5 2",
               done, mem[0], mem[1], count);
    end
  endtask

  task automatic test_random_valid();
    logic [DBus-1:0] vals [5];
    int unsigned idx, ready_bad, wr0, pe0;
    bit ok, xfer;
    vals[0] = 5'd11; vals[1] = 5'd22; vals[2] = 5'd13; vals[3] = 5'd24; vals[4] = 5'd6;
    wr0 = wr_cnt; pe0 = pulse_err; idx = 0; ready_bad = 0;
    pulse_start();
    for (int unsigned cyc = 0; cyc < 200 && idx < 5; cyc++) begin
      in_if.in_valid = 1'($urandom_range(0, 1));
      in_if.in_data  = vals[idx];
      in_if.in_last  = (idx == 4);
      start          = (cyc == 7);
      @(negedge clock);
      xfer = 1'b0;
      if (in_if.in_ready === 1'b1) begin
        if (CS !== 1'b1 || WE !== 1'b1 || OE !== 1'b1 || busy !== 1'b1) ready_bad++;
        xfer = in_if.in_valid;
      end
      @(posedge clock); #1;
      if (xfer) idx++;
    end
    in_if.in_valid = 1'b0; in_if.in_last = 1'b0; start = 1'b0;
    n_checks++;
    if (idx != 5) begin n_fail++; $display("FAIL rand_accepted: got %0d want 5", idx); end
    wait_done(30, ok);
    n_checks++;
    if (!ok || count !== 6'd5 || ready_bad != 0) begin
      n_fail++;
      $display("FAIL rand_status: done=%b count=%0d ready_outside_accept=%0d want 1 5 0",
               done, count, ready_bad);
    end
    n_checks++;
    if (wr_cnt - wr0 != 5 || pulse_err != pe0) begin
      n_fail++;
      $display("FAIL rand_writes: writes=%0d pulse_errs=%0d want 5 0", wr_cnt - wr0, pulse_err - pe0);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (mem[i] !== vals[i]) begin
        n_fail++;
        $display("FAIL rand_ram%0d: got %0d want %0d", i, mem[i], vals[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit acc, ok, found;
    pulse_start();
    send_word(5'd20, 1'b0, 20, acc);
    send_word(5'd5, 1'b0, 20, acc);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (WE === 1'b0 && Address === 5'd1) found = 1'b1;
      else begin @(posedge clock); #1; end
    end
    n_checks++;
    if (!found || count !== 6'd1) begin
      n_fail++;
      $display("FAIL midrst_strobe: strobe_found=%b count=%0d want 1 1", found, count);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b1 || count !== 6'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_flags: busy=%b cpu_hold=%b count=%0d done=%b want 0 1 0 0",
               busy, cpu_hold, count, done);
    end
    n_checks++;
    if (CS !== 1'b1 || WE !== 1'b1 || OE !== 1'b1 || DataMem !== 5'h1f || Address !== 5'h1f) begin
      n_fail++;
      $display("FAIL midrst_bus: CS=%b WE=%b OE=%b D=%h A=%h want released 1 1 1 1f 1f",
               CS, WE, OE, DataMem, Address);
    end
    pulse_start();
    send_word(5'd9, 1'b1, 20, acc);
    wait_done(20, ok);
    n_checks++;
    if (!ok || mem[0] !== 5'd9 || count !== 6'd1) begin
      n_fail++;
      $display("FAIL midrst_reload: done=%b ram0=%0d count=%0d want 1 9 1", done, mem[0], count);
    end
  endtask

`ifdef LOADER_VERIFY_EN
  task automatic test_verify();
    bit acc, ok;
    corrupt_en = 1'b1;
    pulse_start();
    send_word(5'd1, 1'b0, 20, acc);
    send_word(5'd2, 1'b0, 20, acc);
    n_checks++;
    if (err_verify !== 1'b0) begin n_fail++; $display("FAIL verify_early: err_verify=%b want 0", err_verify); end
    send_word(5'd3, 1'b1, 20, acc);
    wait_done(30, ok);
    n_checks++;
    if (!ok || err_verify !== 1'b1 || count !== 6'd3) begin
      n_fail++;
      $display("FAIL verify_result: done=%b err_verify=%b count=%0d want 1 1 3", done, err_verify, count);
    end
    corrupt_en = 1'b0;
  endtask
`endif

  initial begin
    start = 1'b0;
    reset = 1'b1;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    in_if.in_last  = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_restart();
    test_random_valid();
    test_reset_mid_write();
`ifdef LOADER_VERIFY_EN
    test_verify();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
